// File: rtl/bus_memory_responder.sv
// bus_memory_responder
//   Bus target for the memory controller's word read/write requests. A
//   request seen while idle is latched, bus_full is held high for LATENCY
//   cycles, and then the write is committed (per byte lane) or the stored
//   word is returned on bus_rdata, with a one-cycle bus_ack pulse.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for bus_read/bus_write; captures the request on an edge
//   BUSY  | latched request in service; counter runs down to 0, then commit
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   bus_addr   byte address (bits [1:0] and bits above the index ignored)
//   bus_wdata  write data
//   bus_sel    byte-lane enables for writes
//   bus_read   read request
//   bus_write  write request (wins when both strobes are high)
//   bus_rdata  read data, held until the next read completes
//   bus_full   busy; no new request may start while high
//   bus_ack    one-cycle completion pulse
module bus_memory_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic [3:0]  bus_sel,
  input  logic        bus_read,
  input  logic        bus_write,
  output logic [31:0] bus_rdata,
  output logic        bus_full,
  output logic        bus_ack
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic          full_nxt, ack_nxt;
  logic          capture, complete;

  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic [3:0]    sel_q;
  logic          wr_q;

  logic [31:0]   mem [DEPTH];

  // Only the word index of the address is meaningful.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus_addr[31:AW+2], bus_addr[1:0]};

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    full_nxt  = bus_full;
    ack_nxt   = 1'b0;
    capture   = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        if (bus_read || bus_write) begin
          capture   = 1'b1;
          state_nxt = BUSY;
          cnt_nxt   = CNT_INIT;
          full_nxt  = 1'b1;
        end
      end
      BUSY: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          complete  = 1'b1;
          state_nxt = IDLE;
          full_nxt  = 1'b0;
          ack_nxt   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      bus_full  <= 1'b0;
      bus_ack   <= 1'b0;
      bus_rdata <= 32'd0;
      idx_q     <= '0;
      wdata_q   <= 32'd0;
      sel_q     <= 4'd0;
      wr_q      <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      bus_full <= full_nxt;
      bus_ack  <= ack_nxt;
      if (capture) begin
        idx_q   <= bus_addr[AW+1:2];
        wdata_q <= bus_wdata;
        sel_q   <= bus_sel;
        // a simultaneous read+write is serviced as a write only
        wr_q    <= bus_write;
      end
      if (complete && !wr_q) begin
        bus_rdata <= mem[idx_q];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 32'd0;
      end
    end else if (complete && wr_q) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_q[b]) begin
          mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_memory_responder.sv
module tb_bus_memory_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdata;
  logic [3:0]  sel;
  logic        rd, wr;
  logic [31:0] rdata;
  logic        full, ack;

  logic [31:0] a4, d4;
  logic [3:0]  s4;
  logic        r4, w4;
  logic [31:0] rdata4;
  logic        full4, ack4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_memory_responder #(.DEPTH(256), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .bus_addr(addr), .bus_wdata(wdata), .bus_sel(sel),
    .bus_read(rd), .bus_write(wr), .bus_rdata(rdata), .bus_full(full), .bus_ack(ack)
  );

  bus_memory_responder #(.DEPTH(256), .LATENCY(4)) dut4 (
    .clk(clk), .rst(rst), .bus_addr(a4), .bus_wdata(d4), .bus_sel(s4),
    .bus_read(r4), .bus_write(w4), .bus_rdata(rdata4), .bus_full(full4), .bus_ack(ack4)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One full transaction on the LATENCY=2 instance; checks the busy window,
  // the ack pulse and bus_rdata at completion.
  task automatic txn(input logic r, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s,
                     input logic [31:0] exp, input string name);
    @(negedge clk);
    rd = r; wr = w; addr = a; wdata = d; sel = s;
    @(posedge clk);
    @(negedge clk);
    rd = 1'b0; wr = 1'b0;
    chk({name, "_full1"}, 32'(full), 32'd1);
    chk({name, "_ack0"}, 32'(ack), 32'd0);
    for (int i = 1; i < LAT; i++) begin
      @(negedge clk);
      chk({name, "_fullN"}, 32'(full), 32'd1);
      chk({name, "_ackN"}, 32'(ack), 32'd0);
    end
    @(negedge clk);
    chk({name, "_done_full"}, 32'(full), 32'd0);
    chk({name, "_done_ack"}, 32'(ack), 32'd1);
    chk({name, "_rdata"}, rdata, exp);
    @(negedge clk);
    chk({name, "_ack_drop"}, 32'(ack), 32'd0);
  endtask

  initial begin
    int cyc;
    int nacks;
    int last_ack;

    vecs[0]  = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,          4'hF, 32'h0000_0000};
    vecs[1]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF,  4'hF, 32'h0000_0000};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,          4'hF, 32'hDEAD_BEEF};
    vecs[3]  = '{1'b0, 1'b1, 32'h0000_0020, 32'hAAAA_AAAA,  4'hF, 32'hDEAD_BEEF};
    vecs[4]  = '{1'b0, 1'b1, 32'h0000_0020, 32'h1122_3344,  4'h5, 32'hDEAD_BEEF};
    vecs[5]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,          4'h0, 32'hAA22_AA44};
    vecs[6]  = '{1'b1, 1'b0, 32'h0000_0023, 32'h0,          4'h0, 32'hAA22_AA44};
    vecs[7]  = '{1'b0, 1'b1, 32'h0000_0400, 32'h0000_0055,  4'hF, 32'hAA22_AA44};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,          4'h0, 32'h0000_0055};
    vecs[9]  = '{1'b1, 1'b1, 32'h0000_0008, 32'h0000_0077,  4'hF, 32'h0000_0055};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,          4'h0, 32'h0000_0077};
    vecs[11] = '{1'b0, 1'b1, 32'h0000_0020, 32'hFFFF_FFFF,  4'h0, 32'h0000_0077};
    vecs[12] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,          4'h0, 32'hAA22_AA44};
    vecs[13] = '{1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678,  4'h8, 32'hAA22_AA44};
    vecs[14] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,          4'h0, 32'h12AD_BEEF};
    vecs[15] = '{1'b1, 1'b0, 32'h0000_03FC, 32'h0,          4'h0, 32'h0000_0000};
    vecs[16] = '{1'b1, 1'b0, 32'hFFFF_FC10, 32'h0,          4'h0, 32'h12AD_BEEF};

    // reset held with a read request pending
    rst = 1'b0;
    rd = 1'b1; wr = 1'b0; addr = 32'h4; wdata = 32'h0; sel = 4'h0;
    r4 = 1'b0; w4 = 1'b0; a4 = 32'h0; d4 = 32'h0; s4 = 4'h0;
    repeat (2) @(negedge clk);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_full4", 32'(full4), 32'd0);
    rd = 1'b0;
    rst = 1'b1;

    for (int i = 0; i < 17; i++) begin
      txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].sel,
          vecs[i].exp, $sformatf("vec%0d", i));
    end

    // reset one cycle after capturing a write: aborted, nothing committed
    @(negedge clk);
    wr = 1'b1; addr = 32'h30; wdata = 32'h99; sel = 4'hF;
    @(posedge clk);
    @(negedge clk);
    wr = 1'b0;
    chk("midrst_full_before", 32'(full), 32'd1);
    rst = 1'b0;
    #1;
    chk("midrst_full", 32'(full), 32'd0);
    chk("midrst_ack", 32'(ack), 32'd0);
    chk("midrst_rdata", rdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_no_ack", 32'(ack), 32'd0);
    txn(1'b1, 1'b0, 32'h30, 32'h0, 4'h0, 32'h0, "midrst_read30");
    txn(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 32'h0, "midrst_read10");

    // LATENCY=4: inputs change while busy, latched values must be committed
    @(negedge clk);
    w4 = 1'b1; a4 = 32'h40; d4 = 32'hCAFE_F00D; s4 = 4'hF;
    @(posedge clk);
    @(negedge clk);
    w4 = 1'b0; a4 = 32'h44; d4 = 32'h0; s4 = 4'h0;
    cyc = 1;
    while (!ack4 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("busy_ack_latency", 32'(cyc), 32'd5);

    // read held high continuously: one ack every LATENCY+1 = 5 cycles
    r4 = 1'b1; a4 = 32'h40;
    nacks = 0;
    last_ack = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ack4) begin
        nacks++;
        chk($sformatf("b2b_gap%0d", nacks), 32'(i - last_ack), 32'd5);
        chk($sformatf("b2b_rdata%0d", nacks), rdata4, 32'hCAFE_F00D);
        last_ack = i;
      end
      if (i == 20) r4 = 1'b0;
    end
    chk("b2b_count", 32'(nacks), 32'd4);

    // the address presented mid-busy must not have been written
    @(negedge clk);
    r4 = 1'b1; a4 = 32'h44;
    @(posedge clk);
    @(negedge clk);
    r4 = 1'b0;
    cyc = 1;
    while (!ack4 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("busy_read44_latency", 32'(cyc), 32'd5);
    chk("busy_read44_rdata", rdata4, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_memory_responder.md
# bus_memory_responder

Bus-side responder that services the word read/write requests issued by the memory controller on the shared data bus. It latches each request, holds `bus_full` high for a fixed service latency, and then commits the write or returns read data from an internal word-addressed SRAM model. It sits between the memory controller's bus port and the rest of the system, and is the target the controller's `bus_full` / `data_in_BUS` handshake is built against.

## Interface
- `DEPTH`, 256: number of 32-bit words in storage; power of two, 2..4096.
- `LATENCY`, 2: cycles `bus_full` stays high per transaction; 1..15.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `bus_addr`  in  32  byte address from the controller (`address_out`).
- `bus_wdata`  in  32  write data from the controller (`data_out_BUS`).
- `bus_sel`  in  4  byte-lane enables for writes; bit i covers `bus_wdata[8i+7:8i]`.
- `bus_read`  in  1  read request.
- `bus_write`  in  1  write request.
- `bus_rdata`  out  32  read data to the controller (`data_in_BUS`).
- `bus_full`  out  1  responder busy; the controller must not start a new request while high.
- `bus_ack`  out  1  one-cycle completion pulse for reads and writes.

## Operation
- States: IDLE, BUSY. All outputs are registered.
- Reset (`rst` low, any time): state IDLE, `bus_full`=0, `bus_ack`=0, `bus_rdata`=0, counter=0, all storage words=0. Reset mid-transaction aborts it: no write is committed and `bus_rdata` is not updated.
- IDLE, with `bus_read` or `bus_write` high at a rising edge (capture edge):
  - Latch the word index `bus_addr[log2(DEPTH)+1:2]`, `bus_wdata`, `bus_sel`, and the operation.
  - Set `bus_full`=1 and counter=LATENCY-1, then go to BUSY.
- Both `bus_read` and `bus_write` high: treated as a write. No read is performed.
- Address rules:
  - `bus_addr[1:0]` is ignored; accesses are always word-aligned.
  - Address bits above the index are ignored, so addresses wrap modulo DEPTH words.
- BUSY, counter≠0 at an edge: decrement the counter. Inputs are ignored, because latched values are used.
- BUSY, counter=0 at an edge (completion edge):
  - Write: update each byte lane whose `bus_sel` bit is 1. Lanes whose bit is 0 keep their old value. `bus_sel`=0000 completes normally with no change.
  - Read: load `bus_rdata` with the stored word.
  - Both: set `bus_full`=0 and `bus_ack`=1, then go to IDLE.
- `bus_ack` is high only in the cycle after the completion edge, then returns to 0.
- `bus_rdata` holds its value until the next read completes. Writes never change it, including a write to the address last read.
- A request still high at the edge after completion starts a new transaction. The requester must deassert within the `bus_ack` cycle to avoid a repeat.

## Timing
- Capture at edge k: `bus_full` high from k through k+LATENCY. Completion at edge k+LATENCY: `bus_full` low, `bus_ack` high for one cycle, read data valid on `bus_rdata`.
- Read latency is LATENCY cycles from the capture edge. Earliest next capture is edge k+LATENCY+1.
- LATENCY=1: counter starts at 0, so completion happens on the edge immediately after capture.
- Back-to-back requests held high continuously give one transaction every LATENCY+1 cycles.
- Read-after-write to the same word returns the new data, because the write commits on its completion edge, before the read is captured.

## Test plan
- **Power-on reset:** hold `rst`=0 for 2 cycles with `bus_read`=1 and `bus_addr`=0x4 -> `bus_full`=0, `bus_ack`=0, `bus_rdata`=0. Release `rst`, then read 0x4 -> `bus_rdata`=0 after 2 cycles.
- **Write then read:** write 0xDEADBEEF to 0x10 with `bus_sel`=1111. `bus_full` is high exactly 2 cycles, then `bus_ack` pulses. Read 0x10 -> `bus_rdata`=0xDEADBEEF at capture+2.
- **Byte lanes and alignment:**
  - Write 0x11223344 to 0x20 with `bus_sel`=0101 over a word holding 0xAAAAAAAA -> reading 0x20 gives 0xAA22AA44.
  - Read 0x23 -> also returns 0xAA22AA44.
- **Wrap and simultaneous strobes:**
  - With DEPTH=256, write 0x55 to 0x400 -> reading 0x0 returns 0x55.
  - Assert read and write together to 0x8 with data 0x77 -> treated as a write, `bus_rdata` unchanged; a later read of 0x8 returns 0x77.
- **Reset mid-write:** start a write of 0x99 to 0x30, pulse `rst` low one cycle after capture -> `bus_full`=0 immediately, and a read of 0x30 returns 0.
- **Busy behaviour:** with LATENCY=4, change `bus_addr` and `bus_wdata` during BUSY -> the originally latched values are committed. Hold `bus_read` continuously -> `bus_ack` pulses every 5 cycles.
